// File: rtl/cpu_control_unit_if.sv
// Fetch and data-memory handshake bundle for the CPU control unit.
// master: imem_req/imem_addr/dmem_req/dmem_we out; slave: ready/rdata out.
interface cpu_control_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer: owns pc/ir, fetches, gates decode, steps strobes.
// Ports: clk, rst_n, bus (fetch/data handshakes), ir, dec_enable,
// flags_nzcv, alu_enable, flags_we, rf_we, base_we, lr_we, link_addr,
// pc, undef, retired, state (debug).
module cpu_control_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cpu_control_unit_if.master         bus,
    output logic [31:0]                ir,
    output logic                       dec_enable,
    input  logic [3:0]                 flags_nzcv,
    output logic                       alu_enable,
    output logic                       flags_we,
    output logic                       rf_we,
    output logic                       base_we,
    output logic                       lr_we,
    output logic [31:0]                link_addr,
    output logic [31:0]                pc,
    output logic                       undef,
    output logic                       retired,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic        alu_en_q;
    logic        flags_we_q;
    logic        rf_we_q;
    logic        base_we_q;
    logic        lr_we_q;
    logic        wb_ret_q;

    logic        cond_base;
    logic        cond_ok;
    logic        cls_undef;
    logic        is_dp;
    logic        is_ls;
    logic        is_br;
    logic        dp_test;
    logic        issue;
    logic        in_decode;
    logic        wb_rf;
    logic        wb_flags;
    logic        wb_base;
    logic        wb_lr;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    // Condition codes come in true/inverted pairs; bit 28 selects the
    // inverse, except for the 111x pair where 1111 never executes.
    always_comb begin
        cond_base = 1'b0;
        unique case (ir_q[31:29])
            3'd0: cond_base = flags_nzcv[2];
            3'd1: cond_base = flags_nzcv[1];
            3'd2: cond_base = flags_nzcv[3];
            3'd3: cond_base = flags_nzcv[0];
            3'd4: cond_base = flags_nzcv[1] & ~flags_nzcv[2];
            3'd5: cond_base = flags_nzcv[3] == flags_nzcv[0];
            3'd6: cond_base = ~flags_nzcv[2]
                              & (flags_nzcv[3] == flags_nzcv[0]);
            3'd7: cond_base = 1'b1;
            default: cond_base = 1'b0;
        endcase
        if (ir_q[31:29] == 3'd7) begin
            cond_ok = ~ir_q[28];
        end else begin
            cond_ok = cond_base ^ ir_q[28];
        end
    end

    assign cls_undef = (ir_q[27:25] == 3'b100)
                     | (ir_q[27:25] == 3'b110)
                     | (ir_q[27:25] == 3'b111);
    assign is_dp     = ir_q[27:26] == 2'b00;
    assign is_ls     = ir_q[27:26] == 2'b01;
    assign is_br     = ir_q[27:25] == 3'b101;
    assign dp_test   = ir_q[24:23] == 2'b10;

    assign in_decode = state_q == S_DECODE;
    assign issue     = cond_ok & ~cls_undef;

    assign wb_rf    = (is_dp & ~dp_test) | (is_ls & ir_q[20]);
    assign wb_flags = is_dp & (ir_q[20] | dp_test);
    assign wb_base  = is_ls & (~ir_q[24] | ir_q[21]);
    assign wb_lr    = is_br & ir_q[24];

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_q + 32'd8
                     + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            alu_en_q   <= 1'b0;
            flags_we_q <= 1'b0;
            rf_we_q    <= 1'b0;
            base_we_q  <= 1'b0;
            lr_we_q    <= 1'b0;
            wb_ret_q   <= 1'b0;
        end else begin
            alu_en_q   <= 1'b0;
            flags_we_q <= 1'b0;
            rf_we_q    <= 1'b0;
            base_we_q  <= 1'b0;
            lr_we_q    <= 1'b0;
            wb_ret_q   <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    // First cycle out of reset raises the request;
                    // ready only counts once the request is visible.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (bus.imem_ready) begin
                        ir_q       <= bus.imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (issue) begin
                        alu_en_q <= ~is_br;
                        state_q  <= S_EXECUTE;
                    end else begin
                        pc_q       <= pc_plus4;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_EXECUTE: begin
                    if (is_ls) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= ~ir_q[20];
                        state_q    <= S_MEM;
                    end else begin
                        rf_we_q    <= wb_rf;
                        flags_we_q <= wb_flags;
                        base_we_q  <= wb_base;
                        lr_we_q    <= wb_lr;
                        wb_ret_q   <= 1'b1;
                        state_q    <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        rf_we_q    <= wb_rf;
                        flags_we_q <= wb_flags;
                        base_we_q  <= wb_base;
                        lr_we_q    <= wb_lr;
                        wb_ret_q   <= 1'b1;
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    pc_q       <= is_br ? br_target : pc_plus4;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                default: begin
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;

    // Decode-phase strobes depend on the flags seen in DECODE itself.
    assign dec_enable = in_decode & issue;
    assign undef      = in_decode & cond_ok & cls_undef;
    assign retired    = wb_ret_q | (in_decode & ~issue);

    assign alu_enable = alu_en_q;
    assign flags_we   = flags_we_q;
    assign rf_we      = rf_we_q;
    assign base_we    = base_we_q;
    assign lr_we      = lr_we_q;
    assign link_addr  = pc_plus4;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign state      = state_q;

endmodule
